// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for the EGO1 eight-digit seven-segment display.
// Scans digit pairs (k, k+4) with a blanking gap before each pair. Updates go into a
// shadow register and are copied to the active set only at the frame wrap, so a frame
// never shows a mix of old and new data.
module seg_scan_driver #(
  parameter int DRIVE_CYCLES = 99000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk_pin,
  input  logic        rst_pin,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_hex,
  input  logic [7:0]  upd_en,
  input  logic [7:0]  upd_dp,
  output logic [7:0]  seg_data_0_pin,
  output logic [7:0]  seg_data_1_pin,
  output logic [7:0]  seg_cs_pin,
  output logic        frame_start
);

  localparam int MAX_CYCLES = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Scan state
  state_t           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // Update handshake and data registers
  logic        pending_q, pending_d;
  logic        ready_q, ready_d;
  logic [31:0] shadow_hex_q, shadow_hex_d;
  logic [7:0]  shadow_en_q, shadow_en_d;
  logic [7:0]  shadow_dp_q, shadow_dp_d;
  logic [31:0] act_hex_q, act_hex_d;
  logic [7:0]  act_en_q, act_en_d;
  logic [7:0]  act_dp_q, act_dp_d;
  logic        accept;
  logic        copy;

  // Registered outputs
  logic [7:0] seg0_q, seg0_d;
  logic [7:0] seg1_q, seg1_d;
  logic [7:0] cs_q, cs_d;
  logic       frame_q, frame_d;

  // Seven-segment glyph for one hex nibble, bit0 = a ... bit6 = g.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3f;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5b;
      4'h3: g = 7'h4f;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6d;
      4'h6: g = 7'h7d;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7f;
      4'h9: g = 7'h6f;
      4'ha: g = 7'h77;
      4'hb: g = 7'h7c;
      4'hc: g = 7'h39;
      4'hd: g = 7'h5e;
      4'he: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Nibble of digit d (0 = leftmost) from the packed hex value.
  function automatic logic [3:0] digit_nib(input logic [31:0] hex, input logic [2:0] d);
    logic [31:0] shifted;
    shifted = hex >> (5'd28 - {d, 2'b00});
    return shifted[3:0];
  endfunction

  // Full segment byte for digit d, dark when the digit is disabled.
  function automatic logic [7:0] digit_seg(input logic [31:0] hex, input logic [7:0] en,
                                           input logic [7:0] dp, input logic [2:0] d);
    logic [7:0] s;
    s = 8'h00;
    if (en[3'd7 - d]) begin
      s = {dp[3'd7 - d], glyph(digit_nib(hex, d))};
    end
    return s;
  endfunction

  // Next scan state: BLANK -> DRIVE on the same step, DRIVE -> BLANK on the next step.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q + 1'b1;
    wrap    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          k_d     = k_q + 2'd1;
          cnt_d   = '0;
          wrap    = (k_q == 2'd3);
        end
      end
      default: begin
        state_d = ST_BLANK;
        k_d     = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake: one pending update at a time, copied to the active set only at the wrap.
  // An accept and a copy can never coincide because ready is low while pending.
  always_comb begin
    accept       = upd_valid & ready_q;
    copy         = wrap & pending_q;
    pending_d    = pending_q;
    shadow_hex_d = shadow_hex_q;
    shadow_en_d  = shadow_en_q;
    shadow_dp_d  = shadow_dp_q;
    act_hex_d    = act_hex_q;
    act_en_d     = act_en_q;
    act_dp_d     = act_dp_q;
    if (copy) begin
      act_hex_d = shadow_hex_q;
      act_en_d  = shadow_en_q;
      act_dp_d  = shadow_dp_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_hex_d = upd_hex;
      shadow_en_d  = upd_en;
      shadow_dp_d  = upd_dp;
      pending_d    = 1'b1;
    end
    ready_d = ~pending_d;
  end

  // Outputs for the state being entered; they only move on BLANK<->DRIVE edges.
  always_comb begin
    seg0_d  = 8'h00;
    seg1_d  = 8'h00;
    cs_d    = 8'h00;
    frame_d = wrap;
    if (state_d == ST_DRIVE) begin
      seg0_d = digit_seg(act_hex_q, act_en_q, act_dp_q, {1'b0, k_d});
      seg1_d = digit_seg(act_hex_q, act_en_q, act_dp_q, {1'b1, k_d});
      cs_d[3'd7 - {1'b0, k_d}] = act_en_q[3'd7 - {1'b0, k_d}];
      cs_d[3'd7 - {1'b1, k_d}] = act_en_q[3'd7 - {1'b1, k_d}];
    end
  end

  // State, data and output registers; reset darkens the display and drops any pending update.
  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      state_q      <= ST_BLANK;
      k_q          <= 2'd0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
      shadow_hex_q <= '0;
      shadow_en_q  <= '0;
      shadow_dp_q  <= '0;
      act_hex_q    <= '0;
      act_en_q     <= '0;
      act_dp_q     <= '0;
      seg0_q       <= '0;
      seg1_q       <= '0;
      cs_q         <= '0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      shadow_hex_q <= shadow_hex_d;
      shadow_en_q  <= shadow_en_d;
      shadow_dp_q  <= shadow_dp_d;
      act_hex_q    <= act_hex_d;
      act_en_q     <= act_en_d;
      act_dp_q     <= act_dp_d;
      seg0_q       <= seg0_d;
      seg1_q       <= seg1_d;
      cs_q         <= cs_d;
      frame_q      <= frame_d;
    end
  end

  assign upd_ready      = ready_q;
  assign seg_data_0_pin = seg0_q;
  assign seg_data_1_pin = seg1_q;
  assign seg_cs_pin     = cs_q;
  assign frame_start    = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver: directed scenarios plus random updates, every cycle
// compared against a frame-position model (cycle index mod frame length).
module tb_seg_scan_driver;

  localparam int D     = 4;
  localparam int B     = 2;
  localparam int STEP  = D + B;
  localparam int FRAME = 4 * STEP;

  logic        clk = 1'b0;
  logic        rst_pin;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_hex;
  logic [7:0]  upd_en;
  logic [7:0]  upd_dp;
  logic [7:0]  seg0;
  logic [7:0]  seg1;
  logic [7:0]  cs;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_driver #(.DRIVE_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk_pin        (clk),
    .rst_pin        (rst_pin),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_hex        (upd_hex),
    .upd_en         (upd_en),
    .upd_dp         (upd_dp),
    .seg_data_0_pin (seg0),
    .seg_data_1_pin (seg1),
    .seg_cs_pin     (cs),
    .frame_start    (frame_start)
  );

  logic [7:0] glyph_tab [16] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                                 8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71};

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: cycles since reset release, active set, shadow set, pending flag
  int          t;
  logic [31:0] m_hex, s_hex;
  logic [7:0]  m_en, m_dp, s_en, s_dp;
  bit          m_pend;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Expected segment byte of digit d from the model's active set
  function automatic logic [7:0] exp_seg(input int d);
    int nib;
    if (!m_en[7-d]) return 8'h00;
    nib = int'((m_hex >> (28 - 4*d)) & 32'hf);
    return glyph_tab[nib] | (m_dp[7-d] ? 8'h80 : 8'h00);
  endfunction

  task automatic check_cycle();
    int p, step, pos;
    logic [7:0] e_cs, e0, e1;
    p    = t % FRAME;
    step = p / STEP;
    pos  = p % STEP;
    e_cs = 8'h00;
    e0   = 8'h00;
    e1   = 8'h00;
    if (pos >= B) begin
      e_cs[7-step] = m_en[7-step];
      e_cs[3-step] = m_en[3-step];
      e0 = exp_seg(step);
      e1 = exp_seg(step + 4);
    end
    chk("seg_cs",    cs,   e_cs);
    chk("seg_data_0", seg0, e0);
    chk("seg_data_1", seg1, e1);
    chk("frame_start", {7'd0, frame_start}, {7'd0, (p == 0 && t >= FRAME)});
    chk("upd_ready",   {7'd0, upd_ready},   {7'd0, !m_pend});
  endtask

  // One clock cycle: drive inputs, check current outputs, advance model at the edge
  task automatic tick(input bit v, input logic [31:0] hex, input logic [7:0] en,
                      input logic [7:0] dp);
    upd_valid = v;
    upd_hex   = hex;
    upd_en    = en;
    upd_dp    = dp;
    check_cycle();
    @(posedge clk);
    #1;
    if (m_pend) begin
      if ((t % FRAME) == FRAME - 1) begin
        m_hex  = s_hex;
        m_en   = s_en;
        m_dp   = s_dp;
        m_pend = 1'b0;
      end
    end else if (v) begin
      s_hex  = hex;
      s_en   = en;
      s_dp   = dp;
      m_pend = 1'b1;
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) idle(1);
  endtask

  task automatic do_reset(input int n);
    rst_pin   = 1'b1;
    upd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_seg_cs", cs, 8'h00);
    chk("rst_seg_data_0", seg0, 8'h00);
    chk("rst_seg_data_1", seg1, 8'h00);
    chk("rst_frame_start", {7'd0, frame_start}, 8'h00);
    chk("rst_upd_ready", {7'd0, upd_ready}, 8'h01);
    rst_pin = 1'b0;
    t       = 0;
    m_hex   = '0; m_en = '0; m_dp = '0;
    s_hex   = '0; s_en = '0; s_dp = '0;
    m_pend  = 1'b0;
  endtask

  initial begin
    rst_pin   = 1'b1;
    upd_valid = 1'b0;
    upd_hex   = '0;
    upd_en    = '0;
    upd_dp    = '0;
    t         = 0;

    // Reset release, then two idle frames
    do_reset(3);
    idle(48);

    // Full scan with all digits enabled
    run_to(0);
    tick(1'b1, 32'h0123_4567, 8'hff, 8'h00);
    idle(60);

    // Enable and decimal-point masks
    tick(1'b1, 32'h89AB_CDEF, 8'ha5, 8'h81);
    idle(60);

    // Accept during step 2, then a second request while not ready is ignored
    run_to(13);
    tick(1'b1, 32'hFEDC_BA98, 8'hff, 8'h0f);
    for (int i = 0; i < 6; i++) tick(1'b1, 32'h1111_1111, 8'h3c, 8'hff);
    idle(40);

    // Accept on the exact wrap cycle
    run_to(FRAME - 1);
    tick(1'b1, 32'h2468_ACE0, 8'h5a, 8'h24);
    idle(50);

    // Reset during DRIVE of step 1 with an update pending
    run_to(1);
    tick(1'b1, 32'h7777_7777, 8'hff, 8'hff);
    run_to(STEP + B + 1);
    do_reset(1);
    idle(48);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 3) == 0), $urandom, 8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the EGO1 eight-digit seven-segment display. It holds a 32-bit hex value plus per-digit enable and decimal-point masks, and scans the two four-digit groups one position at a time. Each position gets a blanking gap to suppress ghosting. It sits between any value-producing logic and the board pins, and replaces static all-digits-on driving so that every digit can show a different character.

## Interface
- DRIVE_CYCLES, default 99000: cycles each scan position is lit; must be ≥ 1.
- BLANK_CYCLES, default 1000: cycles all digits are dark before each position; must be ≥ 1.
- clk_pin  in  1  system clock. One clock only; reset is synchronous and active-high.
- rst_pin  in  1  synchronous active-high reset.
- upd_valid  in  1  update request.
- upd_ready  out  1  high when an update can be accepted.
- upd_hex  in  32  hex value. Digit d (0 = leftmost … 7 = rightmost) is upd_hex[31-4d -: 4].
- upd_en  in  8  digit enables; upd_en[7-d] enables digit d.
- upd_dp  in  8  decimal points; upd_dp[7-d] lights the dp of digit d.
- seg_data_0_pin  out  8  segments of the left group (digits 0–3), active-high; bit0 = a … bit6 = g, bit7 = dp.
- seg_data_1_pin  out  8  segments of the right group (digits 4–7), same encoding.
- seg_cs_pin  out  8  digit selects, active-high; seg_cs_pin[7-d] selects digit d.
- frame_start  out  1  one-cycle pulse at the start of each scan frame.

## Operation
- Glyphs for nibbles 0–F: 3f 06 5b 4f 66 6d 7d 07 7f 6f 77 7c 39 5e 79 71. Bit7 of the output is OR'd with the digit's dp bit.
- The state machine has two states, BLANK and DRIVE, plus a 2-bit scan step k (0–3) and a cycle counter.
- BLANK: seg_cs_pin = 0, both segment buses = 0. After BLANK_CYCLES cycles, go to DRIVE with the same k.
- DRIVE: step k lights digit k (left group) and digit k+4 (right group) together.
  - seg_cs_pin[7-k] = upd_en bit of digit k.
  - seg_cs_pin[3-k] = upd_en bit of digit k+4.
  - All other select bits = 0.
  - A disabled digit puts 0 on its group's segment bus.
- After DRIVE_CYCLES cycles in DRIVE, go to BLANK with k+1 mod 4.
- The 3→0 wrap is the frame boundary. frame_start pulses on the first BLANK cycle of step 0.
- Shadow/active registers:
  - An update is accepted when upd_valid & upd_ready. It is stored in a shadow register and upd_ready drops.
  - The shadow is copied to the active registers on the frame boundary, so no frame ever mixes old and new data.
  - upd_ready returns high on the cycle after the copy.
- Only the active registers drive the outputs.

## Timing
- All outputs are registered.
- Reset values:
  - seg_data_0_pin = 0, seg_data_1_pin = 0, seg_cs_pin = 0.
  - frame_start = 0, upd_ready = 1.
  - State = BLANK, k = 0, counter = 0.
  - Active and shadow hex/en/dp = 0, so all digits are dark.
- The first cycle after reset release is the first BLANK cycle of step 0. The frame_start pulse for this first frame is not emitted; the first pulse comes at the next 3→0 wrap.
- Frame length is 4·(DRIVE_CYCLES + BLANK_CYCLES) cycles.
- Output selects change on the clock edge that enters a state. Select and segment changes happen only on BLANK↔DRIVE edges, never mid-state.
- Update latency: an update accepted in cycle t is copied at the first frame boundary strictly after t. It becomes visible on the first DRIVE cycle of step 0 after that boundary.
- Simultaneous events:
  - An accept on the exact boundary cycle is held to the following boundary.
  - upd_valid while upd_ready = 0 is ignored; the requester must hold it.
  - The shadow is never overwritten while an update is pending.
- Reset asserted mid-scan: on the next edge, outputs go dark, any pending shadow is discarded, and upd_ready = 1.
- Counters wrap exactly. No cycle is ever skipped or doubled at state transitions.

## Test plan
- Bench parameters: DRIVE_CYCLES = 4, BLANK_CYCLES = 2, giving a 24-cycle frame.
- Reset release:
  - Stimulus: hold no update for 48 cycles.
  - Required: seg_cs_pin = 0 and both buses = 0 throughout; upd_ready = 1; no frame_start in the first frame, then one frame_start per 24 cycles from cycle 24.
- Full scan:
  - Stimulus: update hex = 0x0123_4567, en = ff, dp = 0.
  - Required: per step, selects 0x88 / 0x44 / 0x22 / 0x11. Left bus shows 3f, 06, 5b, 4f; right bus shows 66, 6d, 7d, 07. Each is lit 4 cycles, separated by 2 all-zero cycles.
- Masks:
  - Stimulus: hex = 0x89AB_CDEF, en = 0xA5, dp = 0x81.
  - Required:
    - Step 0: select 0x80, left bus ff (7f | dp), right bus 0.
    - Step 1: select 0x04, left bus 0, right bus 5e.
    - Step 2: select 0x20, left bus 77, right bus 0.
    - Step 3: select 0x01, left bus 0, right bus f1 (71 | dp).
- Tearing/handshake:
  - Stimulus: accept an update during step 2.
  - Required: upd_ready = 0 until the cycle after the next boundary. Steps 2–3 still show the old data; step 0 of the next frame shows the new data.
  - Stimulus: drive a second upd_valid while upd_ready = 0.
  - Required: it is ignored.
- Boundary accept:
  - Stimulus: accept on the exact wrap cycle.
  - Required: the new data first appears one full frame later.
- Reset mid-operation:
  - Stimulus: assert rst_pin during DRIVE of step 1 with an update pending.
  - Required: outputs are 0 on the next edge and upd_ready = 1. After release the display stays dark, because the pending update was dropped.
